mem_wb_pipe: RTL and testbench
==============================

# mem_wb_pipe

MEM/WB pipeline register and write-back stage for the five-stage RV32I pipeline. Captures the `mem_wb_stage_reg_t` produced by the MEM stage and waits for the data-memory response on loads and stores. It extracts and extends load data, drives the register-file write port and forwarding path, and emits exactly one RVFI commit per valid instruction. It is the only producer of the data-memory stall seen by upstream stages.

## Interface
- No parameters.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem_wb_in`  in  `mem_wb_stage_reg_t`  next entry from the MEM stage.
- `freeze`  in  1  global pipeline hold from other stall sources (imem miss).
- `dmem_rdata`  in  32  data-memory read data.
- `dmem_resp`  in  1  data-memory response, one cycle wide per request.
- `dmem_stall`  out  1  entry is waiting on `dmem_resp`; upstream holds.
- `rd_we`  out  1  register-file write enable.
- `rd_addr`  out  5  register-file write index.
- `rd_wdata`  out  32  register-file write data.
- `fwd_valid`  out  1  `rd_wdata` is valid for forwarding to EX.
- `commit_valid`  out  1  RVFI retire strobe.
- `commit_order`  out  64  RVFI order of the retiring entry.
- `commit_load_data`  out  32  raw `dmem_rdata` word captured for the entry, for RVFI mem_rdata.

## Operation
- Holds a single entry register `ent` with a `data_ok` flag and a latched-response register `rdata_q`.
- Memory access: `ent.mem_rmask_s != 0 || ent.mem_wmask_s != 0`.
- States:
  - EMPTY: `ent` invalid.
  - WAIT: valid memory access, no response yet.
  - READY: valid, data available or access not required.
- Load rule: `load_en = !freeze && !dmem_stall`. When `load_en` is high, `ent` captures `mem_wb_in` on the edge.
- Next state after a load:
  - EMPTY if `mem_wb_in.valid_s == 0`.
  - WAIT if the new entry is a memory access.
  - READY otherwise.
- WAIT with `dmem_resp`: latch `rdata_q = dmem_rdata` and go to READY. This applies even while `freeze` is high. A response is never dropped and never re-awaited.
- `dmem_stall = (state == WAIT) && !dmem_resp`. The response is bypassed combinationally, so a one-cycle-latency memory causes no stall.
- Load data source: `dmem_resp ? dmem_rdata : rdata_q`.
  - Byte offset is `ent.alu_out_s[1:0]`, because `dmem_addr_s` has the low bits cleared.
  - `funct3 = ent.inst_s[14:12]`.
  - LB/LBU select the byte at `8*off`, sign- or zero-extended.
  - LH/LHU select the half at `16*off[1]`, extended.
  - LW passes the full word.
- Write-back mux uses `ent.wb_ctrl_s.wb_sel`:
  - `WB_ALU`: `alu_out_s`.
  - `WB_BR`: `{31'b0, br_en_s}`.
  - `WB_PC4`: `pc_s + 4`.
  - `WB_LOAD`: extracted load data.
- Retire condition: `retire = valid && state == READY_or_resp && !freeze`.
- Outputs on retire:
  - `rd_we = wb_ctrl_s.regf_we && rd_s_s != 0`.
  - `commit_valid = 1`.
  - `commit_order = order_s`.
- `fwd_valid` is high whenever `rd_we` would be high, regardless of `freeze`.
- Each entry retires exactly once. After retiring under `load_en == 0` (not possible by construction), it would go to EMPTY. The block asserts on a double commit of the same `order_s`.

## Timing
- Reset (synchronous, active-high): state EMPTY, `ent = '0`, `rdata_q = '0`, `data_ok = 0`. While in reset, all outputs are 0.
- Non-memory instruction: captured at edge N, retires in cycle N (latency 1 from MEM).
- Load with response in the first WAIT cycle: retires that same cycle with `dmem_stall = 0`.
- Response k cycles late: `dmem_stall` is high for k cycles, and the entry retires in the response cycle.
- Response during `freeze`: the data is latched. Retire happens in the first cycle with `freeze == 0`, and `dmem_stall` stays 0 meanwhile.
- Reset mid-WAIT: the entry is discarded, there is no commit, and a later stray `dmem_resp` in EMPTY is ignored.
- A store retires with `rd_we = 0` but still commits.

## Structure
- Add to `rv32i_types`:
  - the `wb_sel_t` enum (`WB_ALU`, `WB_BR`, `WB_PC4`, `WB_LOAD`);
  - `wb_ctrl_t` {`regf_we`, `wb_sel`};
  - a state enum `wb_state_t`.
- `load_f3_*` constants are reused from that package.
- One sub-module, `load_align`: combinational funct3/offset/word to 32-bit extended result. It is also reusable for the RVFI check.

## Test plan
- ADD x5 with alu_out 0x1234, `wb_sel` `WB_ALU` -> next cycle `rd_we=1`, `rd_addr=5`, `rd_wdata=0x1234`, `commit_valid=1`.
- LB, `alu_out=0x1003`, resp in first cycle with `rdata=0x80AABBCC` -> `rd_wdata=0xFFFFFF80`, `dmem_stall=0`.
- LHU, `alu_out=0x2002`, resp delayed 3 cycles with `rdata=0xBEEF0000` -> `dmem_stall` high 3 cycles, then `rd_wdata=0x0000BEEF`, a single commit.
- LW with resp arriving while `freeze=1` for 2 cycles -> no stall, commit once after `freeze` drops, `rd_wdata` equals the latched word.
- SW followed by ADD to x0 -> two commits in order, `rd_we=0` for both.
- `rst` asserted during WAIT, then a stray `dmem_resp` -> no commit, all outputs 0, state EMPTY.

Source files
------------

// File: rtl/mem_wb_pipe_pkg.sv
// Shared types for the MEM/WB register and write-back stage: stage register
// layout, write-back select/control, WB state encoding and load funct3 codes.
package mem_wb_pipe_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_BR   = 2'd1,
    WB_PC4  = 2'd2,
    WB_LOAD = 2'd3
  } wb_sel_t;

  typedef struct packed {
    logic    regf_we;
    wb_sel_t wb_sel;
  } wb_ctrl_t;

  typedef logic [1:0] wb_state_t;
  localparam wb_state_t ST_EMPTY = 2'd0;
  localparam wb_state_t ST_WAIT  = 2'd1;
  localparam wb_state_t ST_READY = 2'd2;

  localparam logic [2:0] load_f3_lb  = 3'b000;
  localparam logic [2:0] load_f3_lh  = 3'b001;
  localparam logic [2:0] load_f3_lw  = 3'b010;
  localparam logic [2:0] load_f3_lbu = 3'b100;
  localparam logic [2:0] load_f3_lhu = 3'b101;

  typedef struct packed {
    logic        valid_s;
    logic [63:0] order_s;
    logic [31:0] pc_s;
    logic [31:0] inst_s;
    logic [31:0] alu_out_s;
    logic [31:0] dmem_addr_s;
    logic        br_en_s;
    logic [4:0]  rd_s_s;
    logic [3:0]  mem_rmask_s;
    logic [3:0]  mem_wmask_s;
    wb_ctrl_t    wb_ctrl_s;
  } mem_wb_stage_reg_t;

  function automatic logic is_mem_access(input mem_wb_stage_reg_t e);
    return (e.mem_rmask_s != 4'd0) || (e.mem_wmask_s != 4'd0);
  endfunction

endpackage

// File: rtl/mem_wb_pipe_if.sv
// Bundle between the MEM stage / data memory (master) and the MEM/WB stage (slave).
interface mem_wb_pipe_if;
  import mem_wb_pipe_pkg::*;

  mem_wb_stage_reg_t mem_wb_in;
  logic              freeze;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              dmem_stall;
  logic              rd_we;
  logic [4:0]        rd_addr;
  logic [31:0]       rd_wdata;
  logic              fwd_valid;
  logic              commit_valid;
  logic [63:0]       commit_order;
  logic [31:0]       commit_load_data;

  modport master (
    output mem_wb_in, freeze, dmem_rdata, dmem_resp,
    input  dmem_stall, rd_we, rd_addr, rd_wdata, fwd_valid,
           commit_valid, commit_order, commit_load_data
  );

  modport slave (
    input  mem_wb_in, freeze, dmem_rdata, dmem_resp,
    output dmem_stall, rd_we, rd_addr, rd_wdata, fwd_valid,
           commit_valid, commit_order, commit_load_data
  );

endinterface

// File: rtl/mem_wb_pipe_load_align.sv
// Combinational load extraction: picks the byte/half/word at the given offset
// and sign- or zero-extends it according to funct3.
module load_align
  import mem_wb_pipe_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword selection only looks at offset[1]; misaligned halves are not split.
  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = word[{offset[1], 4'b0000} +: 16];
    result   = word;
    case (funct3)
      load_f3_lb:  result = {{24{byte_sel[7]}}, byte_sel};
      load_f3_lbu: result = {24'b0, byte_sel};
      load_f3_lh:  result = {{16{half_sel[15]}}, half_sel};
      load_f3_lhu: result = {16'b0, half_sel};
      default:     result = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register and write-back: waits for the data-memory response,
// drives the register-file write port and forwarding, and retires one RVFI commit per entry.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
(
  input logic         clk,
  input logic         rst,
  mem_wb_pipe_if.slave bus
);

  mem_wb_stage_reg_t ent;
  wb_state_t         state;
  logic              data_ok;
  logic [31:0]       rdata_q;
  logic [63:0]       last_order_q;
  logic              committed_q;

  logic        stall;
  logic        load_en;
  logic        entry_ready;
  logic        retire;
  logic        wb_en;
  logic [31:0] load_word;
  logic [31:0] load_value;
  logic [31:0] wb_value;
  logic        unused_ent_bits;

  // The response is bypassed in its own cycle, so a one-cycle memory never stalls.
  assign stall       = (state == ST_WAIT) && !bus.dmem_resp;
  assign load_en     = !bus.freeze && !stall;
  assign entry_ready = ent.valid_s &&
                       (((state == ST_READY) && data_ok) || ((state == ST_WAIT) && bus.dmem_resp));
  assign retire      = entry_ready && !bus.freeze;
  assign wb_en       = entry_ready && ent.wb_ctrl_s.regf_we && (ent.rd_s_s != 5'd0);
  assign load_word   = bus.dmem_resp ? bus.dmem_rdata : rdata_q;

  assign unused_ent_bits = ^{ent.inst_s[31:15], ent.inst_s[11:0], ent.dmem_addr_s,
                             ent.mem_rmask_s, ent.mem_wmask_s};

  load_align u_load_align (
    .funct3 (ent.inst_s[14:12]),
    .offset (ent.alu_out_s[1:0]),
    .word   (load_word),
    .result (load_value)
  );

  always_comb begin
    wb_value = ent.alu_out_s;
    case (ent.wb_ctrl_s.wb_sel)
      WB_ALU:  wb_value = ent.alu_out_s;
      WB_BR:   wb_value = {31'b0, ent.br_en_s};
      WB_PC4:  wb_value = ent.pc_s + 32'd4;
      WB_LOAD: wb_value = load_value;
      default: wb_value = ent.alu_out_s;
    endcase
  end

  // A response that lands while the pipe is held is latched so it is never re-awaited.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_EMPTY;
      ent     <= '0;
      rdata_q <= '0;
      data_ok <= 1'b0;
    end else if (load_en) begin
      ent <= bus.mem_wb_in;
      if (!bus.mem_wb_in.valid_s) begin
        state   <= ST_EMPTY;
        data_ok <= 1'b0;
      end else if (is_mem_access(bus.mem_wb_in)) begin
        state   <= ST_WAIT;
        data_ok <= 1'b0;
      end else begin
        state   <= ST_READY;
        data_ok <= 1'b1;
      end
    end else if ((state == ST_WAIT) && bus.dmem_resp) begin
      rdata_q <= bus.dmem_rdata;
      state   <= ST_READY;
      data_ok <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      committed_q  <= 1'b0;
      last_order_q <= '0;
    end else if (retire) begin
      committed_q  <= 1'b1;
      last_order_q <= ent.order_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && retire && committed_q) begin
      no_double_commit: assert (ent.order_s != last_order_q);
    end
  end

  assign bus.dmem_stall       = !rst && stall;
  assign bus.rd_we            = !rst && retire && wb_en;
  assign bus.fwd_valid        = !rst && wb_en;
  assign bus.rd_addr          = rst ? 5'd0 : ent.rd_s_s;
  assign bus.rd_wdata         = rst ? 32'd0 : wb_value;
  assign bus.commit_valid     = !rst && retire;
  assign bus.commit_order     = (!rst && retire) ? ent.order_s : 64'd0;
  assign bus.commit_load_data = (!rst && retire) ? load_word : 32'd0;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: directed cases followed by randomized traffic,
// responses and freezes; expectations come from a behavioural model of the stage.
module tb_mem_wb_pipe;
  import mem_wb_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_pipe_if bus ();

  mem_wb_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    mem_wb_stage_reg_t e;
    int                delay;
    logic [31:0]       rdata;
  } pend_t;

  typedef struct {
    logic [63:0] order;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] wdata;
    logic        is_mem;
    logic [31:0] load_data;
  } exp_t;

  pend_t       pending_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          fails = 0;
  int          resp_cnt = -1;
  logic [31:0] resp_data = '0;
  logic        waiting = 1'b0;
  logic [63:0] next_order = 64'd1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
    logic [31:0] v;
    case (f3)
      load_f3_lb, load_f3_lbu: begin
        v = (word >> (8 * off)) & 32'hFF;
        if (f3 == load_f3_lb && v >= 32'd128) v = v - 32'd256;
      end
      load_f3_lh, load_f3_lhu: begin
        v = (word >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == load_f3_lh && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic exp_t modelExpect(input pend_t p);
    exp_t x;
    x.order     = p.e.order_s;
    x.rd_we     = p.e.wb_ctrl_s.regf_we && (p.e.rd_s_s != 5'd0);
    x.rd_addr   = p.e.rd_s_s;
    x.is_mem    = (p.e.mem_rmask_s != 4'd0) || (p.e.mem_wmask_s != 4'd0);
    x.load_data = p.rdata;
    case (p.e.wb_ctrl_s.wb_sel)
      WB_BR:   x.wdata = p.e.br_en_s ? 32'd1 : 32'd0;
      WB_PC4:  x.wdata = p.e.pc_s + 32'd4;
      WB_LOAD: x.wdata = modelLoad(p.e.inst_s[14:12], p.e.alu_out_s[1:0], p.rdata);
      default: x.wdata = p.e.alu_out_s;
    endcase
    return x;
  endfunction

  task automatic addEntry(input wb_sel_t sel, input logic we, input logic [4:0] rd,
                          input logic [2:0] f3, input logic [31:0] alu, input logic ld,
                          input logic st, input int delay, input logic [31:0] rdata);
    pend_t p;
    p.e                   = '0;
    p.e.valid_s           = 1'b1;
    p.e.order_s           = next_order;
    next_order            = next_order + 64'd1;
    p.e.pc_s              = $urandom & 32'hFFFF_FFFC;
    p.e.inst_s            = $urandom;
    p.e.inst_s[14:12]     = f3;
    p.e.alu_out_s         = alu;
    p.e.dmem_addr_s       = alu & 32'hFFFF_FFFC;
    p.e.br_en_s           = 1'($urandom);
    p.e.rd_s_s            = rd;
    p.e.mem_rmask_s       = ld ? 4'hF : 4'h0;
    p.e.mem_wmask_s       = st ? 4'hF : 4'h0;
    p.e.wb_ctrl_s.regf_we = we;
    p.e.wb_ctrl_s.wb_sel  = sel;
    p.delay               = delay;
    p.rdata               = rdata;
    pending_q.push_back(p);
  endtask

  task automatic addBubble();
    pend_t p;
    p.e           = '0;
    p.e.alu_out_s = $urandom;
    p.e.rd_s_s    = 5'($urandom_range(0, 31));
    p.delay       = 0;
    p.rdata       = '0;
    pending_q.push_back(p);
  endtask

  task automatic addRandom();
    int         kind;
    logic [4:0] rd;
    logic       we;
    logic [2:0] f3;
    kind = int'($urandom_range(0, 6));
    rd   = 5'($urandom_range(0, 31));
    we   = ($urandom_range(0, 7) != 0);
    case ($urandom_range(0, 4))
      0:       f3 = load_f3_lb;
      1:       f3 = load_f3_lh;
      2:       f3 = load_f3_lw;
      3:       f3 = load_f3_lbu;
      default: f3 = load_f3_lhu;
    endcase
    case (kind)
      0:       addBubble();
      1:       addEntry(WB_ALU, we, rd, 3'b000, $urandom, 1'b0, 1'b0, 0, 32'd0);
      2:       addEntry(WB_BR, we, rd, 3'b001, $urandom, 1'b0, 1'b0, 0, 32'd0);
      3:       addEntry(WB_PC4, we, rd, 3'b000, $urandom, 1'b0, 1'b0, 0, 32'd0);
      4, 5:    addEntry(WB_LOAD, we, rd, f3, $urandom, 1'b1, 1'b0,
                        int'($urandom_range(0, 3)), $urandom);
      default: addEntry(WB_ALU, 1'b0, rd, 3'b010, $urandom, 1'b0, 1'b1,
                        int'($urandom_range(0, 3)), $urandom);
    endcase
  endtask

  // One clock cycle: drive inputs, check the stall against the model, and
  // account for whatever the stage captures at the coming edge.
  task automatic applyStimulus(input logic frz);
    logic  exp_stall;
    logic  cap;
    pend_t p;
    bus.freeze = frz;
    if (resp_cnt == 0) begin
      bus.dmem_resp  = 1'b1;
      bus.dmem_rdata = resp_data;
      resp_cnt       = -1;
    end else begin
      bus.dmem_resp  = 1'b0;
      bus.dmem_rdata = $urandom;
      if (resp_cnt > 0) resp_cnt--;
    end
    if (pending_q.size() != 0) bus.mem_wb_in = pending_q[0].e;
    else                       bus.mem_wb_in = '0;
    exp_stall = !rst && waiting && !bus.dmem_resp;
    @(negedge clk);
    if (!rst) checkOutput("dmem_stall", 64'(bus.dmem_stall), 64'(exp_stall));
    cap = !rst && !frz && !exp_stall;
    if (bus.dmem_resp) waiting = 1'b0;
    if (cap && pending_q.size() != 0) begin
      p = pending_q.pop_front();
      if (p.e.valid_s) begin
        exp_q.push_back(modelExpect(p));
        if (p.e.mem_rmask_s != 4'd0 || p.e.mem_wmask_s != 4'd0) begin
          waiting   = 1'b1;
          resp_cnt  = p.delay;
          resp_data = p.rdata;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
    rst     = 1'b0;
    waiting = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: every commit is matched against the oldest expected retirement.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
        checkOutput("rst_rd_we", 64'(bus.rd_we), 64'd0);
        checkOutput("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
        checkOutput("rst_dmem_stall", 64'(bus.dmem_stall), 64'd0);
        checkOutput("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
        checkOutput("rst_rd_wdata", 64'(bus.rd_wdata), 64'd0);
        checkOutput("rst_commit_order", bus.commit_order, 64'd0);
        checkOutput("rst_commit_load_data", 64'(bus.commit_load_data), 64'd0);
      end else begin
        checkOutput("rd_we_without_commit", 64'(bus.rd_we & ~bus.commit_valid), 64'd0);
        if (bus.commit_valid) begin
          checkOutput("commit_while_frozen", 64'(bus.freeze), 64'd0);
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_commit: got order %0d, expected no commit at %0t",
                     bus.commit_order, $time);
          end else begin
            x = exp_q.pop_front();
            checkOutput("commit_order", bus.commit_order, x.order);
            checkOutput("rd_we", 64'(bus.rd_we), 64'(x.rd_we));
            checkOutput("fwd_valid", 64'(bus.fwd_valid), 64'(x.rd_we));
            if (x.rd_we) begin
              checkOutput("rd_addr", 64'(bus.rd_addr), 64'(x.rd_addr));
              checkOutput("rd_wdata", 64'(bus.rd_wdata), 64'(x.wdata));
            end
            if (x.is_mem) checkOutput("commit_load_data", 64'(bus.commit_load_data),
                                      64'(x.load_data));
          end
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.mem_wb_in  = '0;
    bus.freeze     = 1'b0;
    bus.dmem_rdata = '0;
    bus.dmem_resp  = 1'b0;
    @(posedge clk);
    #1;
    doReset(2);

    $display("[TB] directed: ALU write to x5");
    addEntry(WB_ALU, 1'b1, 5'd5, 3'b000, 32'h1234, 1'b0, 1'b0, 0, 32'd0);
    repeat (2) applyStimulus(1'b0);

    $display("[TB] directed: LB with immediate response");
    addEntry(WB_LOAD, 1'b1, 5'd6, load_f3_lb, 32'h1003, 1'b1, 1'b0, 0, 32'h80AABBCC);
    repeat (2) applyStimulus(1'b0);

    $display("[TB] directed: LHU with 3-cycle late response");
    addEntry(WB_LOAD, 1'b1, 5'd7, load_f3_lhu, 32'h2002, 1'b1, 1'b0, 3, 32'hBEEF0000);
    repeat (6) applyStimulus(1'b0);

    $display("[TB] directed: LW response under freeze");
    addEntry(WB_LOAD, 1'b1, 5'd8, load_f3_lw, 32'h3000, 1'b1, 1'b0, 0, 32'hCAFEF00D);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    repeat (2) applyStimulus(1'b0);

    $display("[TB] directed: SW then ADD x0");
    addEntry(WB_ALU, 1'b0, 5'd3, 3'b010, 32'h4004, 1'b0, 1'b1, 1, $urandom);
    addEntry(WB_ALU, 1'b1, 5'd0, 3'b000, 32'h55, 1'b0, 1'b0, 0, 32'd0);
    repeat (5) applyStimulus(1'b0);

    $display("[TB] directed: reset during WAIT, then stray response");
    addEntry(WB_LOAD, 1'b1, 5'd9, load_f3_lw, 32'h5000, 1'b1, 1'b0, 6, 32'h12345678);
    repeat (3) applyStimulus(1'b0);
    doReset(1);
    repeat (7) applyStimulus(1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if (pending_q.size() < 2) addRandom();
      if ($urandom_range(0, 149) == 0) doReset(1);
      else applyStimulus($urandom_range(0, 4) == 0);
    end

    for (int i = 0; i < 60 && (pending_q.size() != 0 || exp_q.size() != 0); i++)
      applyStimulus(1'b0);
    checkOutput("drain_outstanding", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
